// File: rtl/phase_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phase_pkg
// Brief    : Shared types and default constants for the phase sequencer.
//            Holds the legacy four-phase names and the default depth and
//            counter width used by phase_gen.
// Revision : 1.0 - initial release
// ============================================================================
package phase_pkg;

  // Default sequencer depth and completed-cycle counter width.
  localparam int NUM_PHASES_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  // Legacy four-phase ordering; the binary PHASE output uses these codes.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    UPDATE = 2'd3
  } STATES;

endpackage : phase_pkg
`default_nettype wire

// File: rtl/phase_cyc_cnt.sv
`default_nettype none
// ============================================================================
// Module   : phase_cyc_cnt
// Brief    : Completed-cycle counter. Increments by one on each rising CLK
//            edge where INC is high and wraps modulo 2^W. Asynchronous
//            active-low reset clears the count.
// Revision : 1.0 - initial release
// ============================================================================
module phase_cyc_cnt
  import phase_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         INC,
  output logic [W-1:0] CNT
);

  logic [W-1:0] r_cnt;

  // Count completed cycles; natural overflow gives the modulo-2^W wrap.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (INC) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign CNT = r_cnt;

endmodule : phase_cyc_cnt
`default_nettype wire

// File: rtl/phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : phase_gen
// Brief    : Phase sequencer. Steps through NUM_PHASES phases (binary and
//            registered one-hot outputs), flags the final phase of each
//            cycle on LAST and counts completed cycles.
//            Optional feature macro: PHASE_STEP_EN adds STEP_MODE/STEP ports
//            for single-step operation (one phase per STEP rising edge).
// Revision : 1.0 - initial release
// ============================================================================
module phase_gen
  import phase_pkg::*;
#(
  parameter  int NUM_PHASES = NUM_PHASES_DEF,
  parameter  int CNT_W      = CNT_W_DEF,
  localparam int PHASE_W    = $clog2(NUM_PHASES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  HOLD,
  input  logic                  SYNC,
`ifdef PHASE_STEP_EN
  input  logic                  STEP_MODE,
  input  logic                  STEP,
`endif
  output logic [PHASE_W-1:0]    PHASE,
  output logic [NUM_PHASES-1:0] PHASE_OH,
  output logic                  LAST,
  output logic [CNT_W-1:0]      CYC_CNT
);

  // Code of the final phase in a cycle (UPDATE in the legacy 4-phase order).
  localparam logic [PHASE_W-1:0] c_last_phase = PHASE_W'(NUM_PHASES - 1);

  logic [PHASE_W-1:0]    r_phase;
  logic [NUM_PHASES-1:0] r_phase_oh;
  logic [PHASE_W-1:0]    w_phase_nxt;
  logic [NUM_PHASES-1:0] w_phase_oh_nxt;
  logic                  w_advance;
  logic                  w_at_last;
  logic                  w_in_range;

  // --------------------------------------------------------------------------
  // Advance qualification
  // --------------------------------------------------------------------------
`ifdef PHASE_STEP_EN
  logic r_step_q;
  logic w_step_pulse;

  // Delay STEP by one cycle so its rising edge can be detected.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= STEP;
    end
  end

  // The step edge is consumed whether or not it advances, so a pulse that
  // lands on HOLD or SYNC is dropped rather than replayed later.
  assign w_step_pulse = STEP & ~r_step_q;
  assign w_advance    = EN & ~HOLD & ~SYNC & (~STEP_MODE | w_step_pulse);
`else
  assign w_advance    = EN & ~HOLD & ~SYNC;
`endif

  // --------------------------------------------------------------------------
  // Phase range detection
  // --------------------------------------------------------------------------
  // With a power-of-two depth every encoding is a legal phase; otherwise
  // encodings past the last phase are illegal and get recovered to 0.
  if ((1 << PHASE_W) == NUM_PHASES) begin : g_pow2
    assign w_in_range = 1'b1;
  end else begin : g_npow2
    assign w_in_range = (r_phase <= c_last_phase);
  end

  assign w_at_last = (r_phase == c_last_phase);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // Hold the current phase in both encodings; reset lands on phase 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_phase    <= '0;
      r_phase_oh <= NUM_PHASES'(1);
    end else begin
      r_phase    <= w_phase_nxt;
      r_phase_oh <= w_phase_oh_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Illegal-encoding recovery first, then SYNC restart, then normal advance
  // with wrap from the last phase back to 0.
  always_comb begin
    w_phase_nxt = r_phase;
    if (!w_in_range) begin
      w_phase_nxt = '0;
    end else if (SYNC) begin
      w_phase_nxt = '0;
    end else if (w_advance) begin
      if (w_at_last) begin
        w_phase_nxt = '0;
      end else begin
        w_phase_nxt = r_phase + 1'b1;
      end
    end
  end

  // Decode the next phase to one-hot so the registered PHASE_OH always
  // tracks PHASE exactly; w_phase_nxt is always a legal phase here.
  always_comb begin
    w_phase_oh_nxt = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      w_phase_oh_nxt[i] = (w_phase_nxt == PHASE_W'(i));
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  // LAST marks the edge that completes a cycle; zero latency from advance.
  always_comb begin
    LAST = w_at_last & w_advance;
  end

  assign PHASE    = r_phase;
  assign PHASE_OH = r_phase_oh;

  // --------------------------------------------------------------------------
  // Completed-cycle counter
  // --------------------------------------------------------------------------
  phase_cyc_cnt #(
    .W   (CNT_W)
  ) u_cyc_cnt (
    .CLK (CLK),
    .RST (RST),
    .INC (LAST),
    .CNT (CYC_CNT)
  );

endmodule : phase_gen
`default_nettype wire

// File: tb/tb_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_gen
// Brief    : Self-checking bench for phase_gen. Two instances share stimulus:
//            a 4-phase sequencer with a 4-bit counter and a 5-phase one with
//            a 16-bit counter. Expected values come from a reference model
//            and are queued at drive time, then popped after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_gen;

  logic CLK = 1'b0;
  logic RST;
  logic EN;
  logic HOLD;
  logic SYNC;
  logic STEP_MODE;
  logic STEP;

  logic [1:0]  PHASE4;
  logic [3:0]  PHASE_OH4;
  logic        LAST4;
  logic [3:0]  CYC_CNT4;
  logic [2:0]  PHASE5;
  logic [4:0]  PHASE_OH5;
  logic        LAST5;
  logic [15:0] CYC_CNT5;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int ph4;
    int cnt4;
    int ph5;
    int cnt5;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int m_ph4  = 0;
  int m_cnt4 = 0;
  int m_ph5  = 0;
  int m_cnt5 = 0;
  bit m_stq  = 1'b0;

  bit wrap_seen = 1'b0;

  always #5 CLK = ~CLK;

  phase_gen #(
    .NUM_PHASES (4),
    .CNT_W      (4)
  ) dut4 (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .HOLD      (HOLD),
    .SYNC      (SYNC),
`ifdef PHASE_STEP_EN
    .STEP_MODE (STEP_MODE),
    .STEP      (STEP),
`endif
    .PHASE     (PHASE4),
    .PHASE_OH  (PHASE_OH4),
    .LAST      (LAST4),
    .CYC_CNT   (CYC_CNT4)
  );

  phase_gen #(
    .NUM_PHASES (5),
    .CNT_W      (16)
  ) dut5 (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .HOLD      (HOLD),
    .SYNC      (SYNC),
`ifdef PHASE_STEP_EN
    .STEP_MODE (STEP_MODE),
    .STEP      (STEP),
`endif
    .PHASE     (PHASE5),
    .PHASE_OH  (PHASE_OH5),
    .LAST      (LAST5),
    .CYC_CNT   (CYC_CNT5)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph4  = 0;
    m_cnt4 = 0;
    m_ph5  = 0;
    m_cnt5 = 0;
    m_stq  = 1'b0;
  endtask

  // Drive one cycle of inputs, check LAST before the edge, queue expected
  // state, then compare after the edge.
  task automatic tick(input bit en, input bit hold, input bit sync,
                      input bit smode, input bit step);
    bit   adv;
    exp_t e;
    exp_t o;
    int   prev_cnt4;
    EN        = en;
    HOLD      = hold;
    SYNC      = sync;
    STEP_MODE = smode;
    STEP      = step;
    #1;
    adv = en && !hold && !sync && (!smode || (step && !m_stq));
    chk_eq("last4", {31'd0, LAST4}, {31'd0, (adv && m_ph4 == 3)});
    chk_eq("last5", {31'd0, LAST5}, {31'd0, (adv && m_ph5 == 4)});
    if (sync) begin
      m_ph4 = 0;
      m_ph5 = 0;
    end else if (adv) begin
      if (m_ph4 == 3) m_cnt4 = (m_cnt4 + 1) % 16;
      if (m_ph5 == 4) m_cnt5 = (m_cnt5 + 1) % 65536;
      m_ph4 = (m_ph4 + 1) % 4;
      m_ph5 = (m_ph5 + 1) % 5;
    end
    m_stq = step;
    e.ph4 = m_ph4; e.cnt4 = m_cnt4; e.ph5 = m_ph5; e.cnt5 = m_cnt5;
    sb_q.push_back(e);
    prev_cnt4 = int'(CYC_CNT4);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sb_q.pop_front();
      chk_eq("phase4",  32'(PHASE4),    32'(o.ph4));
      chk_eq("oh4",     32'(PHASE_OH4), 32'(1 << o.ph4));
      chk_eq("cnt4",    32'(CYC_CNT4),  32'(o.cnt4));
      chk_eq("phase5",  32'(PHASE5),    32'(o.ph5));
      chk_eq("oh5",     32'(PHASE_OH5), 32'(1 << o.ph5));
      chk_eq("cnt5",    32'(CYC_CNT5),  32'(o.cnt5));
      chk_eq("range5",  {31'd0, (PHASE5 < 3'd5)}, 32'd1);
    end
    if (prev_cnt4 == 15 && CYC_CNT4 == 4'd0) wrap_seen = 1'b1;
  endtask

  // Bound the run so a stuck DUT still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ph_before;
    RST       = 1'b0;
    EN        = 1'b0;
    HOLD      = 1'b0;
    SYNC      = 1'b0;
    STEP_MODE = 1'b0;
    STEP      = 1'b0;
    model_reset();

    // Reset state held across edges.
    repeat (2) @(posedge CLK);
    #3;
    chk_eq("rst_phase4", 32'(PHASE4),    32'd0);
    chk_eq("rst_oh4",    32'(PHASE_OH4), 32'd1);
    chk_eq("rst_cnt4",   32'(CYC_CNT4),  32'd0);
    chk_eq("rst_phase5", 32'(PHASE5),    32'd0);
    chk_eq("rst_oh5",    32'(PHASE_OH5), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Free run: 9 edges -> 4-phase ends at 1 with two completed cycles;
    // 5-phase walks 0..4,0 along the way.
    repeat (9) tick(1, 0, 0, 0, 0);
    chk_eq("free_phase4", 32'(PHASE4),   32'd1);
    chk_eq("free_cnt4",   32'(CYC_CNT4), 32'd2);
    chk_eq("free_phase5", 32'(PHASE5),   32'd4);

    // Idle: EN low holds everything.
    repeat (2) tick(0, 0, 0, 0, 0);

    // Priority: reach phase 2, HOLD 3 edges, then SYNC with HOLD.
    tick(0, 0, 1, 0, 0);
    repeat (2) tick(1, 0, 0, 0, 0);
    chk_eq("prio_phase2", 32'(PHASE4), 32'd2);
    repeat (3) tick(1, 1, 0, 0, 0);
    chk_eq("hold_phase2", 32'(PHASE4), 32'd2);
    tick(1, 1, 1, 0, 0);
    chk_eq("sync_phase0", 32'(PHASE4), 32'd0);
    chk_eq("sync_cnt4",   32'(CYC_CNT4), 32'd2);

    // Counter wrap: 16 full 4-phase cycles cross 15 -> 0.
    repeat (64) tick(1, 0, 0, 0, 0);
    chk_eq("wrap_seen",  {31'd0, wrap_seen}, 32'd1);
    chk_eq("wrap_cnt4",  32'(CYC_CNT4), 32'd2);

    // Async reset mid-cycle at phase 3.
    tick(0, 0, 1, 0, 0);
    repeat (3) tick(1, 0, 0, 0, 0);
    chk_eq("pre_rst_phase4", 32'(PHASE4), 32'd3);
    #3;
    RST = 1'b0;
    #1;
    chk_eq("arst_phase4", 32'(PHASE4),    32'd0);
    chk_eq("arst_oh4",    32'(PHASE_OH4), 32'd1);
    chk_eq("arst_cnt4",   32'(CYC_CNT4),  32'd0);
    chk_eq("arst_cnt5",   32'(CYC_CNT5),  32'd0);
    model_reset();
    EN = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    // First edge after reset advances only when enabled.
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk_eq("post_rst_phase4", 32'(PHASE4), 32'd1);

`ifdef PHASE_STEP_EN
    // Single step: STEP held high for 5 edges advances once.
    ph_before = int'(PHASE4);
    repeat (5) tick(1, 0, 0, 1, 1);
    chk_eq("step_held", 32'(PHASE4), 32'((ph_before + 1) % 4));
    // Three separate pulses give three advances.
    ph_before = int'(PHASE4);
    repeat (3) begin
      tick(1, 0, 0, 1, 0);
      tick(1, 0, 0, 1, 1);
    end
    chk_eq("step_pulses", 32'(PHASE4), 32'((ph_before + 3) % 4));
    // A pulse landing on HOLD is dropped, not queued.
    ph_before = int'(PHASE4);
    tick(1, 0, 0, 1, 0);
    tick(1, 1, 0, 1, 1);
    tick(1, 0, 0, 1, 1);
    chk_eq("step_hold_drop", 32'(PHASE4), 32'(ph_before));
`else
    ph_before = int'(PHASE4);
    tick(1, 0, 0, 0, 0);
    chk_eq("free_tail", 32'(PHASE4), 32'((ph_before + 1) % 4));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_phase_gen
`default_nettype wire
